systolic_mmu_nxn: RTL and testbench

//   Parametrised NxN output-stationary systolic matrix engine; successor to the fixed 2x2 array + feeder pair.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/systolic_mmu_nxn_if.sv | 31 +++
 rtl/mac_pe.sv | 38 +++
 rtl/systolic_mmu_nxn.sv | 174 +++++++++++++++++
 tb/tb_systolic_mmu_nxn.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, encodings and helpers for the systolic matrix engine
package tpu_pkg;

    // Engine sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } mmu_state_t;

    // Operand buffer select encodings on wr_sel
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Number of FEED cycles needed to push every skewed operand through an n x n grid
    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    // Row-major flat index of element (i, j) in an n x n matrix
    function automatic int rm_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/systolic_mmu_nxn_if.sv
// rtl/systolic_mmu_nxn_if.sv - host-side operand write, control and result read bundle
interface systolic_mmu_nxn_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 2 * DW + $clog2(N)
);
    localparam int IW = $clog2(N * N);

    logic                 wr_en;
    logic                 wr_sel;
    logic [IW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        rd_idx;
    logic signed [AW-1:0] rd_data;

    // Host side drives operands/control and reads results
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, rd_idx,
        input  busy, done, rd_data
    );

    // Engine side
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, rd_idx,
        output busy, done, rd_data
    );

endinterface

// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - signed multiply-accumulate cell with a/b pass-through registers
module mac_pe #(
    parameter int DW = 8,
    parameter int AW = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc
);
    // Product is formed at the wider of the full product and accumulator widths so
    // a narrowed accumulator simply wraps modulo 2^AW.
    localparam int PW = 2 * DW;
    localparam int XW = (AW > PW) ? AW : PW;

    logic signed [XW-1:0] prod;

    assign prod = XW'(a_in) * XW'(b_in);

    // Accumulate and forward operands only while the array is being fed
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + AW'(prod);
        end
    end

endmodule

// File: rtl/systolic_mmu_nxn.sv
// rtl/systolic_mmu_nxn.sv - NxN output-stationary systolic matrix engine; MMU_RELU_EN clamps negative readout to zero
import tpu_pkg::*;

module systolic_mmu_nxn #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 2 * DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    systolic_mmu_nxn_if.slave bus
);
    localparam int NN = N * N;
    localparam int FL = feed_len(N);
    localparam int CW = $clog2(FL);

    mmu_state_t state, state_nxt;
    logic [CW-1:0] feed_cnt;
    logic          busy;
    logic          pe_clr;
    logic          pe_en;
    logic          wr_ok;

    logic signed [DW-1:0] a_buf [NN];
    logic signed [DW-1:0] b_buf [NN];
    logic signed [DW-1:0] a_feed [N];
    logic signed [DW-1:0] b_feed [N];
    logic signed [DW-1:0] a_q [N][N];
    logic signed [DW-1:0] b_q [N][N];
    logic signed [AW-1:0] acc [N][N];
    logic signed [AW-1:0] acc_flat [NN];
    logic signed [AW-1:0] c_sel;
    logic [N-1:0]         unused_a_edge;
    logic [N-1:0]         unused_b_edge;

    // Operand buffers only change while idle; out-of-range addresses are dropped
    assign wr_ok = bus.wr_en && !busy && (int'(bus.wr_addr) < NN);

    // Operand buffer writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else if (wr_ok) begin
            if (bus.wr_sel == SEL_A) begin
                a_buf[bus.wr_addr] <= bus.wr_data;
            end else if (bus.wr_sel == SEL_B) begin
                b_buf[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CLEAR;
            CLEAR:   state_nxt = FEED;
            FEED:    if (feed_cnt == CW'(FL - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs and array controls
    always_comb begin
        busy   = 1'b0;
        pe_clr = 1'b0;
        pe_en  = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                pe_clr = 1'b1;
            end
            FEED: begin
                busy  = 1'b1;
                pe_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = (state == DONE);

    // Feed cycle counter, restarted by CLEAR
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            feed_cnt <= '0;
        end else if (state == FEED) begin
            feed_cnt <= feed_cnt + 1'b1;
        end
    end

    // Skew: row i sees A[i][k-i] and column j sees B[k-j][j] in feed cycle k, zero outside the band
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            for (int m = 0; m < N; m++) begin
                if (pe_en && int'(feed_cnt) == i + m) begin
                    a_feed[i] = a_buf[rm_idx(i, m, N)];
                    b_feed[i] = b_buf[rm_idx(m, i, N)];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] a_in;
            logic signed [DW-1:0] b_in;

            if (j == 0) begin : g_a_edge
                assign a_in = a_feed[i];
            end else begin : g_a_link
                assign a_in = a_q[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in = b_feed[j];
            end else begin : g_b_link
                assign b_in = b_q[i-1][j];
            end

            mac_pe #(
                .DW (DW),
                .AW (AW)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (pe_clr),
                .en    (pe_en),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_q[i][j]),
                .b_out (b_q[i][j]),
                .acc   (acc[i][j])
            );

            assign acc_flat[rm_idx(i, j, N)] = acc[i][j];
        end

        // Operands leaving the far edges of the grid have no consumer
        assign unused_a_edge[i] = ^a_q[i][N-1];
        assign unused_b_edge[i] = ^b_q[N-1][i];
    end

    // Result select; indices beyond the matrix read as zero
    always_comb begin
        c_sel = '0;
        if (int'(bus.rd_idx) < NN) begin
            c_sel = acc_flat[bus.rd_idx];
        end
    end

`ifdef MMU_RELU_EN
    assign bus.rd_data = (c_sel < 0) ? '0 : c_sel;
`else
    assign bus.rd_data = c_sel;
`endif

endmodule

// File: tb/tb_systolic_mmu_nxn.sv
// tb/tb_systolic_mmu_nxn.sv - scoreboard bench for the systolic matrix engine at N=2 and N=4
module tb_systolic_mmu_nxn;

    logic clk = 1'b0;
    logic rst;

    always #50 clk = ~clk;

    systolic_mmu_nxn_if #(.N(2), .DW(8)) bus2 ();
    systolic_mmu_nxn_if #(.N(4), .DW(8)) bus4 ();

    systolic_mmu_nxn #(.N(2), .DW(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    systolic_mmu_nxn #(.N(4), .DW(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    logic       use4;
    logic       wr_en;
    logic       wr_sel;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [3:0] rd_idx;

    assign bus2.wr_en   = wr_en & ~use4;
    assign bus2.wr_sel  = wr_sel;
    assign bus2.wr_addr = wr_addr[1:0];
    assign bus2.wr_data = wr_data;
    assign bus2.start   = start & ~use4;
    assign bus2.rd_idx  = rd_idx[1:0];

    assign bus4.wr_en   = wr_en & use4;
    assign bus4.wr_sel  = wr_sel;
    assign bus4.wr_addr = wr_addr;
    assign bus4.wr_data = wr_data;
    assign bus4.start   = start & use4;
    assign bus4.rd_idx  = rd_idx;

    logic               busy_m;
    logic               done_m;
    logic signed [63:0] rd_m;

    always_comb begin
        busy_m = use4 ? bus4.busy : bus2.busy;
        done_m = use4 ? bus4.done : bus2.done;
        rd_m   = use4 ? 64'(bus4.rd_data) : 64'(bus2.rd_data);
    end

    int checks = 0;
    int errors = 0;
    int ma [16];
    int mb [16];
    int sb [$];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MMU_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = 8'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) mb[addr] = data;
        else     ma[addr] = data;
    endtask

    task automatic load(input int a [16], input int b [16]);
        int nn;
        nn = use4 ? 4 : 2;
        for (int k = 0; k < nn * nn; k++) begin
            wr(1'b0, k, a[k]);
            wr(1'b1, k, b[k]);
        end
    endtask

    // Start a multiply from a negedge in IDLE; expected C is queued up front and
    // popped when done appears. tail = extra cycles watched after the done cycle.
    task automatic run(input string name, input int tail, input int inj_cyc);
        int nn;
        int cyc;
        int ndone;
        int first;
        int c;
        nn    = use4 ? 4 : 2;
        ndone = 0;
        first = 0;
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
                c = 0;
                for (int m = 0; m < nn; m++) c += ma[i*nn+m] * mb[m*nn+j];
                sb.push_back(relu(c));
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({name, "_busy"}, longint'(busy_m), 1);
        while (cyc <= 3 * nn + tail) begin
            if (cyc == inj_cyc) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = 8'd9;
                start   = 1'b1;
            end
            if (done_m) begin
                ndone++;
                if (ndone == 1) begin
                    first = cyc;
                    for (int k = 0; k < nn * nn; k++) begin
                        rd_idx = 4'(k);
                        #1;
                        check($sformatf("%s_c%0d", name, k), rd_m, longint'(sb.pop_front()));
                    end
                end
            end
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            cyc++;
        end
        check({name, "_done_cycle"}, first, 3 * nn);
        check({name, "_done_pulses"}, ndone, 1);
        sb.delete();
    endtask

    task automatic check_cleared(input string name);
        check({name, "_busy0"}, longint'(busy_m), 0);
        check({name, "_done0"}, longint'(done_m), 0);
        for (int k = 0; k < 4; k++) begin
            rd_idx = 4'(k);
            #1;
            check($sformatf("%s_rd%0d", name, k), rd_m, 0);
        end
    endtask

    int a_t1 [16];
    int b_t1 [16];
    int a_t2 [16];
    int b_t2 [16];
    int a_id [16];
    int b_seq [16];

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        a_t1 = '{0:1, 1:2, 2:3, 3:4, default:0};
        b_t1 = '{0:5, 1:6, 2:7, 3:8, default:0};
        a_t2 = '{default:-128};
        b_t2 = '{default:127};
        for (int k = 0; k < 16; k++) begin
            a_id[k]  = (k / 4 == k % 4) ? 1 : 0;
            b_seq[k] = k;
            ma[k]    = 0;
            mb[k]    = 0;
        end

        rst     = 1'b1;
        use4    = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        rd_idx  = 4'd0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic 2x2 product: 19, 22, 43, 50
        load(a_t1, b_t1);
        run("basic", 2, 0);

        // Extreme operands: every element -32512
        load(a_t2, b_t2);
        run("extreme", 2, 0);

        // Write and start while busy are both dropped
        load(a_t1, b_t1);
        run("busy_inj", 6, 2);

        // Back-to-back runs must not accumulate across runs
        run("b2b_first", 0, 0);
        run("b2b_second", 2, 0);

        // Reset during FEED cycle 2 aborts and clears everything
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("midrst");
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ma[k] = 0;
            mb[k] = 0;
        end
        @(negedge clk);
        load(a_t1, b_t1);
        run("after_rst", 2, 0);

        // 4x4 identity times index matrix
        use4 = 1'b1;
        @(negedge clk);
        load(a_id, b_seq);
        run("n4_ident", 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
